// File: rtl/burst_line_ctrl_if.sv
// Request/response and burst-RAM signal bundle for burst_line_ctrl.
// master = client plus RAM environment, slave = the controller.
interface burst_line_ctrl_if #(
   parameter int DEPTH_BITWIDTH = 4,
   parameter int DATA_BITWIDTH  = 64,
   parameter int BURST_COUNT    = 4
);
   localparam int LINE_ADDR_W = DEPTH_BITWIDTH - $clog2(BURST_COUNT);
   localparam int LINE_W      = BURST_COUNT * DATA_BITWIDTH;

   logic                         req_valid;
   logic                         req_ready;
   logic                         req_write;
   logic [LINE_ADDR_W-1:0]       req_line_addr;
   logic [LINE_W-1:0]            req_wr_line;
   logic                         resp_valid;
   logic [LINE_W-1:0]            resp_rd_line;
   logic                         ram_cmd;
   logic                         ram_cmd_en;
   logic [DEPTH_BITWIDTH-1:0]    ram_addr;
   logic [DATA_BITWIDTH-1:0]     ram_wr_data;
   logic [DATA_BITWIDTH/8-1:0]   ram_data_mask;
   logic [DATA_BITWIDTH-1:0]     ram_rd_data;
   logic                         ram_rd_data_valid;
   logic                         ram_busy;

   modport master (
      output req_valid, req_write, req_line_addr, req_wr_line,
             ram_rd_data, ram_rd_data_valid, ram_busy,
      input  req_ready, resp_valid, resp_rd_line,
             ram_cmd, ram_cmd_en, ram_addr, ram_wr_data, ram_data_mask
   );

   modport slave (
      input  req_valid, req_write, req_line_addr, req_wr_line,
             ram_rd_data, ram_rd_data_valid, ram_busy,
      output req_ready, resp_valid, resp_rd_line,
             ram_cmd, ram_cmd_en, ram_addr, ram_wr_data, ram_data_mask
   );
endinterface

// File: rtl/burst_line_ctrl.sv
// Cache-line client controller: one handshake becomes one burst command,
// write words are streamed on the RAM schedule and read bursts are gathered.
module burst_line_ctrl #(
   parameter int DEPTH_BITWIDTH = 4,
   parameter int DATA_BITWIDTH  = 64,
   parameter int BURST_COUNT    = 4
) (
   input logic             clk,
   input logic             rst_n,
   burst_line_ctrl_if.slave bus
);
   localparam int CNT_W  = $clog2(BURST_COUNT);
   localparam int LINE_W = BURST_COUNT * DATA_BITWIDTH;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_COUNT - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WR_STREAM, WR_WAIT, RD_COLLECT} state_t;

   state_t                      r_state;
   logic                        r_write;
   logic [CNT_W-1:0]            r_cnt;
   logic [DATA_BITWIDTH-1:0]    r_wrWords [BURST_COUNT];
   logic [DATA_BITWIDTH-1:0]    r_rdWords [BURST_COUNT];
   logic                        r_cmdEn;
   logic                        r_cmd;
   logic [DEPTH_BITWIDTH-1:0]   r_ramAddr;
   logic [DATA_BITWIDTH-1:0]    r_wrData;
   logic                        r_respValid;
   logic [LINE_W-1:0]           r_rdLine;

   logic                        w_accept;
   logic [CNT_W-1:0]            w_nextCnt;
   logic [LINE_W-1:0]           w_fullLine;

   assign bus.req_ready     = rst_n && (r_state == IDLE) && !bus.ram_busy;
   assign w_accept          = bus.req_valid && bus.req_ready;
   assign w_nextCnt         = r_cnt + CNT_W'(1);
   assign bus.resp_valid    = r_respValid;
   assign bus.resp_rd_line  = r_rdLine;
   assign bus.ram_cmd       = r_cmd;
   assign bus.ram_cmd_en    = r_cmdEn;
   assign bus.ram_addr      = r_ramAddr;
   assign bus.ram_wr_data   = r_wrData;
   assign bus.ram_data_mask = '0;

   // The last word is taken straight from the RAM so the line is complete on its arrival edge.
   always_comb begin
      w_fullLine = '0;
      for (int i = 0; i < BURST_COUNT; i++) begin
         if (i == BURST_COUNT - 1)
            w_fullLine[i*DATA_BITWIDTH +: DATA_BITWIDTH] = bus.ram_rd_data;
         else
            w_fullLine[i*DATA_BITWIDTH +: DATA_BITWIDTH] = r_rdWords[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_write     <= 1'b0;
         r_cnt       <= '0;
         r_cmdEn     <= 1'b0;
         r_cmd       <= 1'b0;
         r_ramAddr   <= '0;
         r_wrData    <= '0;
         r_respValid <= 1'b0;
         r_rdLine    <= '0;
         for (int i = 0; i < BURST_COUNT; i++) begin
            r_wrWords[i] <= '0;
            r_rdWords[i] <= '0;
         end
      end else begin
         r_cmdEn     <= 1'b0;
         r_respValid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               // Command is registered on the accept edge so the strobe lands in the ISSUE cycle.
               if (w_accept) begin
                  r_write   <= bus.req_write;
                  r_cnt     <= '0;
                  r_cmdEn   <= 1'b1;
                  r_cmd     <= bus.req_write;
                  r_ramAddr <= {bus.req_line_addr, {CNT_W{1'b0}}};
                  for (int i = 0; i < BURST_COUNT; i++)
                     r_wrWords[i] <= bus.req_wr_line[i*DATA_BITWIDTH +: DATA_BITWIDTH];
                  if (bus.req_write)
                     r_wrData <= bus.req_wr_line[DATA_BITWIDTH-1:0];
                  r_state   <= ISSUE;
               end
            end
            ISSUE: begin
               if (r_write) begin
                  r_wrData <= r_wrWords[w_nextCnt];
                  r_cnt    <= w_nextCnt;
                  r_state  <= WR_STREAM;
               end else begin
                  r_state  <= RD_COLLECT;
               end
            end
            WR_STREAM: begin
               r_cnt <= w_nextCnt;
               if (r_cnt == LAST)
                  r_state <= WR_WAIT;
               else
                  r_wrData <= r_wrWords[w_nextCnt];
            end
            WR_WAIT: begin
               if (!bus.ram_busy) begin
                  r_respValid <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            RD_COLLECT: begin
               if (bus.ram_rd_data_valid) begin
                  r_rdWords[r_cnt] <= bus.ram_rd_data;
                  r_cnt            <= w_nextCnt;
                  if (r_cnt == LAST) begin
                     r_rdLine    <= w_fullLine;
                     r_respValid <= 1'b1;
                     r_state     <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/burst_line_ctrl.md
Name: burst_line_ctrl

Overview:
- Client-side controller directly upstream of the burst RAM.
- Turns single-handshake cache-line read/write requests into one burst command each.
- Streams write words on the RAM's burst schedule and collects read bursts into a full line.
- Its RAM-side ports connect 1:1 to the burst RAM; the top level drives the RAM's active-high reset from ~rst_n.

Parameters:
DEPTH_BITWIDTH, 4, RAM word-address width (2^DEPTH_BITWIDTH words of DATA_BITWIDTH).
DATA_BITWIDTH, 64, RAM word width; divisible by 8.
BURST_COUNT, 4, words per burst/line; power of two, >=2.
(derived) LINE_ADDR_W = DEPTH_BITWIDTH - $clog2(BURST_COUNT); LINE_W = BURST_COUNT*DATA_BITWIDTH.

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  client request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  0: read line, 1: write line
req_line_addr  in  LINE_ADDR_W  line index
req_wr_line  in  LINE_W  write line; word k at [k*DATA_BITWIDTH +: DATA_BITWIDTH]
resp_valid  out  1  one-cycle completion pulse (read and write)
resp_rd_line  out  LINE_W  read line; valid with resp_valid, held until next read completes
ram_cmd  out  1  0: read, 1: write
ram_cmd_en  out  1  command strobe
ram_addr  out  DEPTH_BITWIDTH  {line_addr, $clog2(BURST_COUNT) zero bits}
ram_wr_data  out  DATA_BITWIDTH  burst write word
ram_data_mask  out  DATA_BITWIDTH/8  constant 0
ram_rd_data  in  DATA_BITWIDTH  burst read word
ram_rd_data_valid  in  1  ram_rd_data valid
ram_busy  in  1  RAM busy

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; ram_cmd_en, ram_cmd, ram_addr, ram_wr_data, resp_valid, resp_rd_line, word counter = 0. req_ready = 0 while rst_n=0.
- Reset mid-operation aborts the transfer; no resp_valid. The RAM is reset by the same reset.
- req_ready = rst_n && state==IDLE && !ram_busy (combinational).
- All other outputs are registered.
- States: IDLE, ISSUE, WR_STREAM, WR_WAIT, RD_COLLECT.
- IDLE: on accept at cycle T, latch the request and set k=0; go to ISSUE.
- ISSUE (cycle T+1):
  - ram_cmd_en=1 for exactly this cycle; ram_cmd, ram_addr driven from the latched request.
  - ram_wr_data = word0 (writes).
  - Next state: WR_STREAM if write, else RD_COLLECT.
- WR_STREAM: ram_wr_data = word k during cycle T+1+k, for k=1..BURST_COUNT-1 (one word per cycle, no stalls). After word BURST_COUNT-1, go to WR_WAIT.
- WR_WAIT: when ram_busy==0, pulse resp_valid and go to IDLE. With the RAM's schedule, resp_valid is high in cycle T+BURST_COUNT+3.
- RD_COLLECT:
  - Each cycle with ram_rd_data_valid=1, store ram_rd_data into word slot k and increment k.
  - Latency-agnostic: wait indefinitely for valid.
  - After slot BURST_COUNT-1 is stored, update resp_rd_line with the complete line, pulse resp_valid the next cycle, and go to IDLE.
  - Expected timing with RAM read latency C: resp_valid in cycle T+C+BURST_COUNT+3.
- ram_rd_data_valid outside RD_COLLECT is ignored.
- Writes never modify resp_rd_line.
- Back-to-back: the completion cycle (resp_valid=1, IDLE, ram_busy=0) allows acceptance of the next request.
- ram_cmd_en is never asserted while ram_busy=1 or outside ISSUE.
- Line address wraps naturally: the last line maps to the top BURST_COUNT RAM words.
- Counter k is $clog2(BURST_COUNT) bits wide; its wrap to 0 at completion is intentional.

Test Plan:
- Read, defaults, RAM read latency 8, RAM preloaded so word i = i: read line 1 accepted at T -> one ram_cmd_en pulse at T+1 with ram_addr=4; resp_valid only at T+15; resp_rd_line = {7,6,5,4}.
- Write line 2 with {0xD,0xC,0xB,0xA} accepted at T -> ram_addr=8 at T+1; ram_wr_data A,B,C,D in T+1..T+4; resp_valid at T+7. Read line 2 returns {0xD,0xC,0xB,0xA}.
- Back-to-back: write line 0 then read line 0 requested in the write's completion cycle -> accepted that cycle; read returns the written data; no overlapping ram_cmd_en.
- req_valid held high during a transfer -> req_ready=0 until completion; exactly one command per accepted request; resp_rd_line unchanged by the write.
- Wrap: read line 3 -> ram_addr=12; data words 12..15 returned in order.
- Reset asserted in RD_COLLECT after 2 words -> no resp_valid; all outputs 0 next cycle. After release, read line 1 completes normally with {7,6,5,4}.
